// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add sequencer: drives an external ripple-carry adder to form an
// unsigned WIDTH x WIDTH -> 2*WIDTH product, one add/shift iteration per clock.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     R,
  input  logic                 Cout,
  output logic [WIDTH-1:0]     Aout,
  output logic [WIDTH-1:0]     Bout,
  output logic                 Add_Sub,
  output logic [2*WIDTH-1:0]   P,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // {Cout, R, q} is shifted right as one word so the adder carry is never lost.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      acc <= '0;
      q   <= '0;
      m   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            acc <= '0;
            q   <= B;
            m   <= A;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= {Cout, R[WIDTH-1:1]};
          q   <= {R[0], q[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    Bout       = '0;
    Aout       = acc;
    Add_Sub    = 1'b0;
    P          = {acc, q};
    case (state)
      IDLE: begin
        if (Start) state_next = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (q[0]) Bout = m;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
